// File: rtl/cmp_pkg.sv
// Shared types and mode constants for the slice-serial magnitude comparator.
package cmp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } cmp_state_t;

    localparam logic CMP_UNSIGNED = 1'b0;
    localparam logic CMP_SIGNED   = 1'b1;

endpackage

// File: rtl/cmp_slice.sv
// Combinational MSB-first magnitude compare of one W-bit slice.
module cmp_slice #(
    parameter int W = 2
) (
    input  logic [W-1:0] a_slice,
    input  logic [W-1:0] b_slice,
    output logic         slice_eq,
    output logic         slice_gt
);

    // The first differing bit from the top decides; later bits are ignored.
    always_comb begin
        slice_eq = 1'b1;
        slice_gt = 1'b0;
        for (int i = W - 1; i >= 0; i--) begin
            if (slice_eq && (a_slice[i] != b_slice[i])) begin
                slice_eq = 1'b0;
                slice_gt = a_slice[i];
            end
        end
    end

endmodule

// File: rtl/iterative_comparator.sv
// Slice-serial signed/unsigned magnitude comparator with valid/ready on both sides.
module iterative_comparator
    import cmp_pkg::*;
#(
    parameter int BIT_COUNT   = 8,
    parameter int SLICE_WIDTH = 2,
    parameter int EARLY_EXIT  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BIT_COUNT-1:0] a,
    input  logic [BIT_COUNT-1:0] b,
    input  logic                 signed_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BIT_COUNT-1:0] xor_result,
    output logic                 equal,
    output logic                 a_larger,
    output logic                 a_smaller,
    output logic                 busy
);

    localparam int NUM_SLICES = BIT_COUNT / SLICE_WIDTH;
    localparam int IDX_W      = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;

    cmp_state_t           state_q, state_d;
    logic [BIT_COUNT-1:0] a_q, a_d;
    logic [BIT_COUNT-1:0] b_q, b_d;
    logic                 mode_q, mode_d;
    logic [BIT_COUNT-1:0] xor_q, xor_d;
    logic                 eq_q, eq_d;
    logic                 gt_q, gt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;

    logic [BIT_COUNT-1:0]   bias_a, bias_b;
    logic [BIT_COUNT-1:0]   sh_a, sh_b;
    logic [SLICE_WIDTH-1:0] sl_a, sl_b;
    logic                   slice_eq, slice_gt;

    // Flipping the sign bit maps two's-complement order onto unsigned order.
    always_comb begin
        bias_a = a_q;
        bias_b = b_q;
        if (mode_q == CMP_SIGNED) begin
            bias_a[BIT_COUNT-1] = ~a_q[BIT_COUNT-1];
            bias_b[BIT_COUNT-1] = ~b_q[BIT_COUNT-1];
        end
        sh_a = bias_a >> (int'(idx_q) * SLICE_WIDTH);
        sh_b = bias_b >> (int'(idx_q) * SLICE_WIDTH);
        sl_a = sh_a[SLICE_WIDTH-1:0];
        sl_b = sh_b[SLICE_WIDTH-1:0];
    end

    cmp_slice #(
        .W(SLICE_WIDTH)
    ) u_slice (
        .a_slice (sl_a),
        .b_slice (sl_b),
        .slice_eq(slice_eq),
        .slice_gt(slice_gt)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        mode_d  = mode_q;
        xor_d   = xor_q;
        eq_d    = eq_q;
        gt_d    = gt_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    mode_d  = signed_mode;
                    xor_d   = a ^ b;
                    eq_d    = 1'b1;
                    gt_d    = 1'b0;
                    idx_d   = IDX_W'(NUM_SLICES - 1);
                    state_d = SCAN;
                end
            end
            SCAN: begin
                eq_d = eq_q & slice_eq;
                gt_d = gt_q | (eq_q & slice_gt);
                if ((idx_q == '0) || ((EARLY_EXIT != 0) && !slice_eq)) begin
                    state_d = DONE;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            mode_q  <= CMP_UNSIGNED;
            xor_q   <= '0;
            eq_q    <= 1'b0;
            gt_q    <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            mode_q  <= mode_d;
            xor_q   <= xor_d;
            eq_q    <= eq_d;
            gt_q    <= gt_d;
            idx_q   <= idx_d;
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign out_valid  = (state_q == DONE);
    assign xor_result = xor_q;
    assign equal      = out_valid & eq_q;
    assign a_larger   = out_valid & gt_q;
    assign a_smaller  = out_valid & ~eq_q & ~gt_q;

endmodule
